top_memory_test: RTL and testbench

- Top-level image memory-path block for the JPEG front end.
- Holds an input image SRAM (MEM_IN) and an output SRAM (MEM_OUT), each 32768 words x 64 bit. One word is one 8-pixel row of an 8x8 block, one byte per pixel; 4096 blocks in total.
- After reset release, a sequencer streams every word from MEM_IN through a per-byte datapath stage into the same address of MEM_OUT, then stops.
- The bench preloads MEM_IN and dumps MEM_OUT through hierarchical paths.

---
 rtl/mem_test_pkg.sv | 32 +++
 rtl/top_memory_test_if.sv | 16 +
 rtl/top_memory_test_sram.sv | 70 +++++++
 rtl/top_memory_test.sv | 107 ++++++++++
 tb/tb_top_memory_test.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_test_pkg.sv
// Shared constants, sequencer state encoding and byte-lane helper for the
// JPEG front-end memory path (input SRAM -> per-byte stage -> output SRAM).
// Imported by the bus interface, the SRAM model and the top.
package mem_test_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 32768;
   localparam int LANES  = DATA_W / 8;

   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
   localparam logic [7:0]        LEVEL_OFFSET = 8'h80;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } seq_state_e;

   // Subtracting 128 from an unsigned pixel gives the same two's-complement
   // bit pattern as flipping the MSB, so each lane is a plain XOR.
   function automatic logic [DATA_W-1:0] level_shift(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         r[8*k +: 8] = w[8*k +: 8] ^ LEVEL_OFFSET;
      end
      return r;
   endfunction

endpackage

// File: rtl/top_memory_test_if.sv
// Single-port SRAM bus: chip enable, write enable, address, write data and
// registered read data (valid the cycle after the address).
// master = requester (sequencer side), slave = SRAM side.
interface top_memory_test_if;
   import mem_test_pkg::*;

   logic              ce;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output ce, we, addr, wdata, input rdata);
   modport slave  (input ce, we, addr, wdata, output rdata);

endinterface

// File: rtl/top_memory_test_sram.sv
// Synchronous single-port 32768x64 SRAM model, wrapped twice so the storage
// sits at <inst>.SRAM_syn.SRAM32768x64.Mem for backdoor load/dump.
// Ports: clk_i, bus (slave modport). Write at the edge; read data registered
// (1-cycle latency); no backpressure. Mem is never reset.
module sram_32768x64_core
   import mem_test_pkg::*;
(
   input  logic              clk_i,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] Mem [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_q;

   // Contents deliberately have no reset so preloaded images survive it.
   always_ff @(posedge clk_i) begin
      if (ce_i) begin
         if (we_i) begin
            Mem[addr_i] <= wdata_i;
         end else begin
            rdata_q <= Mem[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

module sram_32768x64_syn
   import mem_test_pkg::*;
(
   input  logic              clk_i,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   sram_32768x64_core SRAM32768x64 (
      .clk_i   (clk_i),
      .ce_i    (ce_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o)
   );

endmodule

module sram_32768x64 (
   input logic               clk_i,
   top_memory_test_if.slave  bus
);

   sram_32768x64_syn SRAM_syn (
      .clk_i   (clk_i),
      .ce_i    (bus.ce),
      .we_i    (bus.we),
      .addr_i  (bus.addr),
      .wdata_i (bus.wdata),
      .rdata_o (bus.rdata)
   );

endmodule

// File: rtl/top_memory_test.sv
// Memory-path top: after reset release streams all 32768 words of MEM_IN
// through a per-byte stage into the same address of MEM_OUT, then idles in DONE.
// Latency 2 cycles read->write, 1 word/cycle, no backpressure.
// Ports: clk (rising edge), reset (async, active low). Status is internal (done).
// Build option LEVEL_SHIFT_EN: each byte lane becomes in - 128 (in ^ 8'h80);
// otherwise the stage is an identity copy with identical timing.
module top_memory_test
   import mem_test_pkg::*;
(
   input logic clk,
   input logic reset
);

   top_memory_test_if in_bus ();
   top_memory_test_if out_bus ();

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              rd_vld_q;     // MEM_IN read data valid this cycle
   logic              pipe_vld_q;   // pipe_dat_q holds a word to write
   logic [DATA_W-1:0] pipe_dat_q;
   logic [DATA_W-1:0] xform_dat;
   logic              rd_en;
   logic              wr_en;
   logic              done;

   // ---------------- sequencer: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- sequencer: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = RUN;
         RUN:   if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
         DRAIN: if (wr_en && (wr_addr_q == LAST_ADDR)) state_d = DONE;
         DONE:  state_d = DONE;
      endcase
   end

   // ---------------- sequencer: outputs ----------------
   // Writes are gated only by the pipeline valid bit, whose reset value is
   // known, so the write strobe can never meet an undefined address.
   always_comb begin
      rd_en = (state_q == RUN);
      wr_en = pipe_vld_q;
      done  = (state_q == DONE);
   end

   // Address counters saturate at the last word instead of wrapping.
   always_comb begin
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      if (rd_en && (rd_addr_q != LAST_ADDR)) rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (wr_en && (wr_addr_q != LAST_ADDR)) wr_addr_d = wr_addr_q + ADDR_W'(1);
   end

   // ---------------- per-byte datapath ----------------
`ifdef LEVEL_SHIFT_EN
   assign xform_dat = level_shift(in_bus.rdata);
`else
   assign xform_dat = in_bus.rdata;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         rd_vld_q   <= 1'b0;
         pipe_vld_q <= 1'b0;
         pipe_dat_q <= '0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         rd_vld_q   <= rd_en;
         pipe_vld_q <= rd_vld_q;
         if (rd_vld_q) pipe_dat_q <= xform_dat;
      end
   end

   // ---------------- SRAM buses ----------------
   assign in_bus.ce     = rd_en;
   assign in_bus.we     = 1'b0;
   assign in_bus.addr   = rd_addr_q;
   assign in_bus.wdata  = '0;

   assign out_bus.ce    = wr_en;
   assign out_bus.we    = wr_en;
   assign out_bus.addr  = wr_addr_q;
   assign out_bus.wdata = pipe_dat_q;

   sram_32768x64 MEM_IN  (.clk_i(clk), .bus(in_bus.slave));
   sram_32768x64 MEM_OUT (.clk_i(clk), .bus(out_bus.slave));

   // The done flag and MEM_OUT's read port have no consumer inside this block;
   // they remain reachable hierarchically for debug.
   logic unused_status;
   assign unused_status = done ^ (^out_bus.rdata);

endmodule

// File: tb/tb_top_memory_test.sv
module tb_top_memory_test;
   import mem_test_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   top_memory_test dut (
      .clk   (clk),
      .reset (reset)
   );

   // Tap of the MEM_OUT write bus for the scoreboard monitor.
   top_memory_test_if mon_if ();
   assign mon_if.ce    = dut.out_bus.ce;
   assign mon_if.we    = dut.out_bus.we;
   assign mon_if.addr  = dut.out_bus.addr;
   assign mon_if.wdata = dut.out_bus.wdata;
   assign mon_if.rdata = dut.out_bus.rdata;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   // Directed words: index 2*run -> address 0, 2*run+1 -> address 32767.
   logic [63:0] dir_in [4] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                               64'h00FF80017F10EFAA, 64'hFEDCBA9876543210};
`ifdef LEVEL_SHIFT_EN
   logic [63:0] dir_exp [4] = '{64'h81A3C5E7092B4D6F, 64'h7E5C3A18F6D4B290,
                                64'h807F0081FF906F2A, 64'h7E5C3A18F6D4B290};
`else
   logic [63:0] dir_exp [4] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                64'h00FF80017F10EFAA, 64'hFEDCBA9876543210};
`endif

   function automatic logic [63:0] in_word(input int i, input int r);
      logic [7:0] b;
      b = i[7:0];
      if (i == 0) return dir_in[2*r];
      if (i == DEPTH-1) return dir_in[2*r+1];
      return {8{b}};
   endfunction

   function automatic logic [63:0] exp_word(input int i, input int r);
      logic [7:0] b;
      b = i[7:0];
`ifdef LEVEL_SHIFT_EN
      b = b ^ 8'h80;
`endif
      if (i == 0) return dir_exp[2*r];
      if (i == DEPTH-1) return dir_exp[2*r+1];
      return {8{b}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mon_if.ce && mon_if.we) begin
         tests++;
         if (!reset) begin
            fails++;
            $display("FAIL write_in_reset: addr=%0d data=%h, required no write", mon_if.addr, mon_if.wdata);
         end else if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mon_if.addr, mon_if.wdata);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_if.addr !== mon_e.addr || mon_if.wdata !== mon_e.data) begin
               fails++;
               $display("FAIL out_write: got addr=%0d data=%h required addr=%0d data=%h",
                        mon_if.addr, mon_if.wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic preload(input int r);
      for (int i = 0; i < DEPTH; i++) begin
         dut.MEM_IN.SRAM_syn.SRAM32768x64.Mem[i] <= in_word(i, r);
         dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[i] <= 64'hDEADBEEFDEADBEEF;
      end
   endtask

   task automatic fill_queue(input int r);
      exp_t e;
      sb_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         e.addr = ADDR_W'(i);
         e.data = exp_word(i, r);
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string name);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 33000) begin
         @(posedge clk);
         cnt++;
         #1;
         if (dut.done === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_timeout: done not seen after %0d cycles, required by 32772", name, cnt);
      end else if (cnt < 32770 || cnt > 32772) begin
         fails++;
         $display("FAIL %s_latency: done after %0d cycles, required 32771 +/- 1", name, cnt);
      end
   endtask

   task automatic scan_out(input string name, input int r);
      int mism;
      int first_bad;
      mism = 0;
      first_bad = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[i] !== exp_word(i, r)) begin
            if (first_bad < 0) first_bad = i;
            mism++;
         end
      end
      tests++;
      if (mism != 0) begin
         fails++;
         $display("FAIL %s: %0d words differ (first at %0d), required 0", name, mism, first_bad);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"},   64'(dut.state_q),    64'(IDLE));
      check({tag, "_done"},    64'(dut.done),       64'd0);
      check({tag, "_rd_addr"}, 64'(dut.rd_addr_q),  64'd0);
      check({tag, "_wr_addr"}, 64'(dut.wr_addr_q),  64'd0);
      check({tag, "_vld"},     64'({dut.rd_vld_q, dut.pipe_vld_q}), 64'd0);
      check({tag, "_ce"},      64'({dut.in_bus.ce, mon_if.ce}),     64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int mism_in;
      int drops;

      // Run A: reset preservation, then full copy with boundary words.
      #2 reset = 1'b0;
      preload(0);
      repeat (50) @(posedge clk);
      #1;
      check_idle("rst");
      mism_in = 0;
      for (int i = 0; i < DEPTH; i++)
         if (dut.MEM_IN.SRAM_syn.SRAM32768x64.Mem[i] !== in_word(i, 0)) mism_in++;
      check("mem_in_kept", 64'(mism_in), 64'd0);
      check("mem_out_untouched", dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[0], 64'hDEADBEEFDEADBEEF);

      fill_queue(0);
      @(negedge clk);
      reset = 1'b1;
      wait_done("runA");
      check("runA_sb_drained", 64'(sb_q.size()), 64'd0);
      drops = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (dut.done !== 1'b1) drops++;
      end
      check("runA_done_hold", 64'(drops), 64'd0);
      check("runA_out_first", dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[0], dir_exp[0]);
      check("runA_out_last",  dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[DEPTH-1], dir_exp[1]);
      scan_out("runA_scan", 0);

      // Run B: new image, reset asserted mid-run, copy restarts from 0.
      @(negedge clk);
      reset = 1'b0;
      preload(1);
      fill_queue(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (1000) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_idle("midrst");
      fill_queue(1);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_hold_state", 64'(dut.state_q), 64'(IDLE));
      check("midrst_hold_done",  64'(dut.done),    64'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_done("runB");
      check("runB_sb_drained", 64'(sb_q.size()), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("runB_done_hold", 64'(dut.done), 64'd1);
      check("runB_out_first", dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[0], dir_exp[2]);
      check("runB_out_last",  dut.MEM_OUT.SRAM_syn.SRAM32768x64.Mem[DEPTH-1], dir_exp[3]);
      scan_out("runB_scan", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
